// File: rtl/bpsk_bit_sync.sv
// Hysteresis bit slicer with symbol-timing recovery for the BPSK demodulator output.
// Bit period = shortest accepted edge interval per window; bits are sampled at mid-bit.
module bpsk_bit_sync #(
  parameter int DATA_W     = 10,
  parameter int MID        = 512,
  parameter int HYST       = 32,
  parameter int CNT_W      = 16,
  parameter int MIN_PERIOD = 16,
  parameter int EDGE_WIN   = 8
) (
  input  logic              clk_8192k,
  input  logic              rst_n,
  input  logic              en,
  input  logic              lock,
  input  logic [DATA_W-1:0] demod_in,
  output logic              bit_out,
  output logic              bit_valid,
  output logic [CNT_W-1:0]  bit_period,
  output logic              sync
);

  localparam int EC_W = $clog2(EDGE_WIN + 1);
  localparam logic [DATA_W:0]  THR_HI  = (DATA_W+1)'(MID + HYST);
  localparam logic [DATA_W:0]  THR_LO  = (DATA_W+1)'(MID - HYST);
  localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(MIN_PERIOD);
  localparam logic [EC_W-1:0]  EW_LAST = EC_W'(EDGE_WIN - 1);

  typedef enum logic [1:0] {IDLE, ACQ, TRACK} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              sliced_q, sliced_d;
  logic              sliced_dly_q, sliced_dly_d;
  logic [CNT_W-1:0]  icnt_q, icnt_d;
  logic [CNT_W-1:0]  min_int_q, min_int_d;
  logic [EC_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic              armed_q, armed_d;
  logic [CNT_W-1:0]  pcnt_q, pcnt_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic              bit_out_q, bit_out_d;
  logic              bit_valid_q, bit_valid_d;

  logic              run;
  logic              edge_det;
  logic              acc_edge;
  logic              win_end;
  logic              expire;
  logic [CNT_W-1:0]  cand;

  assign run      = en & lock;
  assign edge_det = sliced_q ^ sliced_dly_q;
  assign acc_edge = edge_det && (icnt_q >= MIN_P);
  assign cand     = (icnt_q < min_int_q) ? icnt_q : min_int_q;
  assign win_end  = run && acc_edge && armed_q && (edge_cnt_q == EW_LAST) &&
                    (state_q != IDLE);
  assign expire   = (state_q == TRACK) && (pcnt_q == CNT_W'(1));

  always_ff @(posedge clk_8192k or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (run) state_d = ACQ;
      ACQ:     if (!run) state_d = IDLE;
               else if (win_end) state_d = TRACK;
      TRACK:   if (!run) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sync       = (state_q == TRACK);
    bit_valid  = bit_valid_q;
    bit_out    = bit_out_q;
    bit_period = period_q;
  end

  always_comb begin
    din_d        = demod_in;
    sliced_dly_d = sliced_q;

    sliced_d = sliced_q;
    if ({1'b0, din_q} >= THR_HI) begin
      sliced_d = 1'b1;
    end else if ({1'b0, din_q} <= THR_LO) begin
      sliced_d = 1'b0;
    end

    if (acc_edge) begin
      icnt_d = CNT_W'(1);
    end else if (icnt_q == '1) begin
      icnt_d = icnt_q;
    end else begin
      icnt_d = icnt_q + CNT_W'(1);
    end

    // The first accepted edge after entering ACQ only arms the window: the
    // interval counted before it started in IDLE and is meaningless.
    min_int_d  = min_int_q;
    edge_cnt_d = edge_cnt_q;
    armed_d    = armed_q;
    period_d   = period_q;
    if (state_q == IDLE) begin
      if (run) begin
        min_int_d  = '1;
        edge_cnt_d = '0;
        armed_d    = 1'b0;
      end
    end else if (run && acc_edge) begin
      if (!armed_q) begin
        armed_d = 1'b1;
      end else if (edge_cnt_q == EW_LAST) begin
        period_d   = cand;
        min_int_d  = '1;
        edge_cnt_d = '0;
      end else begin
        min_int_d  = cand;
        edge_cnt_d = edge_cnt_q + EC_W'(1);
      end
    end

    // Realign uses the period in force before this cycle's window update.
    pcnt_d = pcnt_q;
    if (state_q == TRACK) begin
      if (pcnt_q != '0) pcnt_d = pcnt_q - CNT_W'(1);
      if (expire)       pcnt_d = period_q;
      if (acc_edge)     pcnt_d = period_q >> 1;
    end else if ((state_q == ACQ) && win_end) begin
      pcnt_d = cand >> 1;
    end

    bit_valid_d = expire;
    bit_out_d   = bit_out_q;
    if (expire) begin
      bit_out_d = edge_det ? sliced_dly_q : sliced_q;
    end
  end

  always_ff @(posedge clk_8192k or negedge rst_n) begin
    if (!rst_n) begin
      din_q        <= '0;
      sliced_q     <= 1'b0;
      sliced_dly_q <= 1'b0;
      icnt_q       <= '0;
      min_int_q    <= '0;
      edge_cnt_q   <= '0;
      armed_q      <= 1'b0;
      pcnt_q       <= '0;
      period_q     <= '0;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
    end else begin
      din_q        <= din_d;
      sliced_q     <= sliced_d;
      sliced_dly_q <= sliced_dly_d;
      icnt_q       <= icnt_d;
      min_int_q    <= min_int_d;
      edge_cnt_q   <= edge_cnt_d;
      armed_q      <= armed_d;
      pcnt_q       <= pcnt_d;
      period_q     <= period_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
    end
  end

endmodule

// File: tb/tb_bpsk_bit_sync.sv
// Directed bench for bpsk_bit_sync: each table row holds one input level for a
// number of cycles and the bits, sync and period expected by the end of it.
module tb_bpsk_bit_sync;

  logic        clk_8192k = 1'b0;
  logic        rst_n;
  logic        en;
  logic        lock;
  logic [9:0]  demod_in;
  logic        bit_out;
  logic        bit_valid;
  logic [15:0] bit_period;
  logic        sync;

  always #5 clk_8192k = ~clk_8192k;

  bpsk_bit_sync #(
    .DATA_W(10), .MID(512), .HYST(32), .CNT_W(16), .MIN_PERIOD(16), .EDGE_WIN(8)
  ) dut (
    .clk_8192k (clk_8192k),
    .rst_n     (rst_n),
    .en        (en),
    .lock      (lock),
    .demod_in  (demod_in),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .bit_period(bit_period),
    .sync      (sync)
  );

  typedef struct {
    logic [9:0]  val;
    int          cyc;
    int          nval;
    logic [3:0]  bits;
    logic        sync;
    logic [15:0] period;
  } vec_t;

  vec_t       tbl_a[$];
  vec_t       tbl_b[$];
  int         checks   = 0;
  int         failures = 0;
  int         got_n;
  logic [3:0] got_bits;

  function automatic vec_t mk(input logic [9:0] v, input int c, input int n,
                              input logic [3:0] b, input logic s, input logic [15:0] p);
    vec_t t;
    t.val = v; t.cyc = c; t.nval = n; t.bits = b; t.sync = s; t.period = p;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Hold one level for n cycles, collecting every strobed bit (newest in bit 0).
  task automatic run(input logic [9:0] v, input int n);
    demod_in = v;
    got_n    = 0;
    got_bits = '0;
    repeat (n) begin
      @(posedge clk_8192k);
      #1;
      if (bit_valid === 1'b1) begin
        got_n++;
        got_bits = {got_bits[2:0], bit_out};
      end
    end
  endtask

  task automatic apply(input vec_t t, input string tag, input int i);
    run(t.val, t.cyc);
    chk($sformatf("%s[%0d].nvalid", tag, i), got_n, t.nval);
    chk($sformatf("%s[%0d].bits", tag, i), got_bits, t.bits);
    chk($sformatf("%s[%0d].sync", tag, i), sync, t.sync);
    chk($sformatf("%s[%0d].period", tag, i), bit_period, t.period);
  endtask

  initial begin
    // Acquisition on 1010 at 100 cycles, 1100 in track, spike, in-band hold.
    tbl_a.push_back(mk(10'd312,  30, 0, 4'd0, 1'b0, 16'd0));
    for (int i = 1; i <= 8; i++)
      tbl_a.push_back(mk((i % 2) ? 10'd712 : 10'd312, 100, 0, 4'd0, 1'b0, 16'd0));
    tbl_a.push_back(mk(10'd712, 100, 1, 4'd1, 1'b1, 16'd100));
    tbl_a.push_back(mk(10'd312, 100, 1, 4'd0, 1'b1, 16'd100));
    tbl_a.push_back(mk(10'd712, 100, 1, 4'd1, 1'b1, 16'd100));
    tbl_a.push_back(mk(10'd312, 100, 1, 4'd0, 1'b1, 16'd100));
    tbl_a.push_back(mk(10'd712, 200, 2, 4'd3, 1'b1, 16'd100));
    tbl_a.push_back(mk(10'd312, 200, 2, 4'd0, 1'b1, 16'd100));
    tbl_a.push_back(mk(10'd712, 200, 2, 4'd3, 1'b1, 16'd100));
    tbl_a.push_back(mk(10'd312, 200, 2, 4'd0, 1'b1, 16'd100));
    tbl_a.push_back(mk(10'd712, 100, 1, 4'd1, 1'b1, 16'd100));
    tbl_a.push_back(mk(10'd312,   4, 0, 4'd0, 1'b1, 16'd100));
    tbl_a.push_back(mk(10'd900,   5, 0, 4'd0, 1'b1, 16'd100));
    tbl_a.push_back(mk(10'd312,  91, 1, 4'd0, 1'b1, 16'd100));
    tbl_a.push_back(mk(10'd712, 100, 1, 4'd1, 1'b1, 16'd100));
    tbl_a.push_back(mk(10'd312, 100, 1, 4'd0, 1'b1, 16'd100));
    tbl_a.push_back(mk(10'd530, 300, 3, 4'd0, 1'b1, 16'd100));
    tbl_a.push_back(mk(10'd712, 100, 1, 4'd1, 1'b1, 16'd100));
    tbl_a.push_back(mk(10'd312, 100, 1, 4'd0, 1'b1, 16'd100));
    tbl_a.push_back(mk(10'd712, 100, 1, 4'd1, 1'b1, 16'd100));
    tbl_a.push_back(mk(10'd312, 100, 1, 4'd0, 1'b1, 16'd100));
    tbl_a.push_back(mk(10'd712, 100, 1, 4'd1, 1'b1, 16'd100));

    // Re-acquisition on mixed 100/200 intervals: minimum must come out as 100.
    tbl_b.push_back(mk(10'd712, 200, 0, 4'd0, 1'b0, 16'd100));
    tbl_b.push_back(mk(10'd312, 100, 0, 4'd0, 1'b0, 16'd100));
    tbl_b.push_back(mk(10'd712, 100, 0, 4'd0, 1'b0, 16'd100));
    tbl_b.push_back(mk(10'd312, 200, 0, 4'd0, 1'b0, 16'd100));
    tbl_b.push_back(mk(10'd712, 200, 0, 4'd0, 1'b0, 16'd100));
    tbl_b.push_back(mk(10'd312, 100, 0, 4'd0, 1'b0, 16'd100));
    tbl_b.push_back(mk(10'd712, 200, 0, 4'd0, 1'b0, 16'd100));
    tbl_b.push_back(mk(10'd312, 200, 0, 4'd0, 1'b0, 16'd100));
    tbl_b.push_back(mk(10'd712, 100, 1, 4'd1, 1'b1, 16'd100));
    tbl_b.push_back(mk(10'd312, 100, 1, 4'd0, 1'b1, 16'd100));
    tbl_b.push_back(mk(10'd712, 153, 2, 4'd3, 1'b1, 16'd100));

    rst_n    = 1'b0;
    en       = 1'b0;
    lock     = 1'b0;
    demod_in = 10'd512;
    #12;
    chk("reset.bit_out", bit_out, 0);
    chk("reset.bit_valid", bit_valid, 0);
    chk("reset.bit_period", bit_period, 0);
    chk("reset.sync", sync, 0);

    @(posedge clk_8192k);
    #1;
    rst_n = 1'b1;
    en    = 1'b1;
    lock  = 1'b1;

    for (int i = 0; i < tbl_a.size(); i++) apply(tbl_a[i], "a", i);

    // lock drop for 10 cycles while tracking
    run(10'd312, 20);
    chk("pre_drop.nvalid", got_n, 0);
    chk("pre_drop.sync", sync, 1);
    lock = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_8192k);
      #1;
      chk($sformatf("drop[%0d].sync", i), sync, 0);
      chk($sformatf("drop[%0d].bit_valid", i), bit_valid, 0);
    end
    chk("drop.bit_period", bit_period, 100);
    lock = 1'b1;
    run(10'd312, 70);
    chk("relock.nvalid", got_n, 0);
    chk("relock.sync", sync, 0);

    for (int i = 0; i < tbl_b.size(); i++) apply(tbl_b[i], "b", i);

    // asynchronous reset while a bit strobe is showing
    chk("pre_rst.bit_valid", bit_valid, 1);
    chk("pre_rst.bit_out", bit_out, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst.bit_valid", bit_valid, 0);
    chk("rst.bit_out", bit_out, 0);
    chk("rst.bit_period", bit_period, 0);
    chk("rst.sync", sync, 0);
    @(posedge clk_8192k);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk_8192k);
    #1;
    chk("post_rst.sync", sync, 0);
    chk("post_rst.bit_period", bit_period, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
